mem_port_arbiter: RTL

Shares the single-port unified instruction/data memory between three requesters: CPU data port (ld/st), CPU instruction fetch, and the host/debug port. Sits between the processor core and the memory macro, replacing the direct `mem_sel` multiplexing. Fixed priority data > fetch > host, with an aging override so the host cannot starve. Optional host lock grants the port exclusively for debug bursts.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_age_ctr.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter: requester ids, FSM states
// and the default address/data widths of the memory macro.
package mem_arb_pkg;

    localparam int DEFAULT_AW = 16;
    localparam int DEFAULT_DW = 16;

    typedef enum logic [1:0] {
        PORT_DATA  = 2'd0,
        PORT_FETCH = 2'd1,
        PORT_HOST  = 2'd2,
        PORT_NONE  = 2'd3
    } port_e;

    typedef enum logic {
        ARB       = 1'b0,
        HOST_LOCK = 1'b1
    } state_e;

endpackage

// File: rtl/mem_arb_age_ctr.sv
// Saturating up-counter with clear priority; used both for host aging and for
// bounding the length of a host lock.
module mem_arb_age_ctr #(
    parameter  int MAX = 8,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MAX_V)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign sat = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data > fetch > host with host aging override and
// an optional bounded host lock for debug bursts.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW            = DEFAULT_AW,
    parameter int DW            = DEFAULT_DW,
    parameter int HOST_MAX_WAIT = 8,
    parameter int LOCK_MAX      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_req,
    input  logic          f_req,
    input  logic          h_req,
    input  logic          d_we,
    input  logic          h_we,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] h_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] h_wdata,
    input  logic          h_lock,
    output logic          d_gnt,
    output logic          f_gnt,
    output logic          h_gnt,
    output logic          d_rvalid,
    output logic          f_rvalid,
    output logic          h_rvalid,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int AGE_W  = $clog2(HOST_MAX_WAIT + 1);
    localparam int LOCK_W = $clog2(LOCK_MAX + 1);

    state_e           state_q;
    state_e           state_d;
    port_e            winner;
    port_e            owner_q;
    port_e            owner_d;
    logic             rd_valid_q;
    logic             rd_valid_d;
    logic [AW-1:0]    addr_q;
    logic [AW-1:0]    addr_d;
    logic [DW-1:0]    wdata_q;
    logic [DW-1:0]    wdata_d;

    logic [AGE_W-1:0] host_age;
    logic [LOCK_W-1:0] lock_cnt;
    logic             host_sat;
    logic             lock_sat;
    logic             age_inc;
    logic             age_clr;
    logic             lock_inc;
    logic             lock_clr;
    logic             in_arb;
    logic             lock_exit;
    logic             unused_cnt;

    assign in_arb    = (state_q == ARB);
    assign lock_exit = (state_q == HOST_LOCK) && (!h_lock || lock_sat);

    // Aging only runs while arbitrating; it is frozen for the whole lock.
    assign age_inc  = in_arb && h_req && !h_gnt;
    assign age_clr  = in_arb && (h_gnt || !h_req);
    assign lock_inc = (in_arb && h_gnt && h_lock) || (!in_arb && !lock_exit);
    assign lock_clr = !in_arb && lock_exit;

    mem_arb_age_ctr #(
        .MAX (HOST_MAX_WAIT)
    ) u_host_age (
        .clk   (clk),
        .reset (reset),
        .inc   (age_inc),
        .clr   (age_clr),
        .cnt   (host_age),
        .sat   (host_sat)
    );

    mem_arb_age_ctr #(
        .MAX (LOCK_MAX)
    ) u_lock_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lock_inc),
        .clr   (lock_clr),
        .cnt   (lock_cnt),
        .sat   (lock_sat)
    );

    // Counter values are only observed through their saturation flags.
    assign unused_cnt = ^{host_age, lock_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB:       if (h_gnt && h_lock) state_d = HOST_LOCK;
            HOST_LOCK: if (lock_exit) state_d = ARB;
            default:   state_d = ARB;
        endcase
    end

    // The lock exit cycle falls through to normal priority arbitration.
    always_comb begin
        winner    = PORT_NONE;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_we    = 1'b0;
        if (reset) begin
            winner = PORT_NONE;
        end else if ((state_q == HOST_LOCK) && !lock_exit) begin
            if (h_req) winner = PORT_HOST;
        end else if (h_req && host_sat) begin
            winner = PORT_HOST;
        end else if (d_req) begin
            winner = PORT_DATA;
        end else if (f_req) begin
            winner = PORT_FETCH;
        end else if (h_req) begin
            winner = PORT_HOST;
        end
        case (winner)
            PORT_DATA: begin
                mem_addr  = d_addr;
                mem_wdata = d_wdata;
                mem_we    = d_we;
            end
            PORT_FETCH: begin
                mem_addr = f_addr;
            end
            PORT_HOST: begin
                mem_addr  = h_addr;
                mem_wdata = h_wdata;
                mem_we    = h_we;
            end
            default: begin
                mem_we = 1'b0;
            end
        endcase
    end

    assign d_gnt = (winner == PORT_DATA);
    assign f_gnt = (winner == PORT_FETCH);
    assign h_gnt = (winner == PORT_HOST);

    always_comb begin
        rd_valid_d = (winner != PORT_NONE) && !mem_we;
        owner_d    = winner;
        addr_d     = mem_addr;
        wdata_d    = mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            owner_q    <= PORT_NONE;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign d_rvalid = rd_valid_q && (owner_q == PORT_DATA);
    assign f_rvalid = rd_valid_q && (owner_q == PORT_FETCH);
    assign h_rvalid = rd_valid_q && (owner_q == PORT_HOST);
    assign rdata    = rd_valid_q ? mem_rdata : '0;

endmodule
